// File: rtl/iob_vexriscv_bus_bridge.sv
// Bridge from a VexRiscv cmd/rsp stream port to an IOb native master:
// an in-order command FIFO, a single-outstanding issue FSM and an optional timeout.
module iob_vexriscv_bus_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 2,
  parameter int WRITE_RSP = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_mask,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_error,
  output logic                iob_valid,
  output logic [ADDR_W-1:0]   iob_address,
  output logic [DATA_W-1:0]   iob_wdata,
  output logic [DATA_W/8-1:0] iob_wstrb,
  input  logic                iob_ready,
  input  logic [DATA_W-1:0]   iob_rdata,
  output logic                busy,
  output logic                err_sticky,
  output logic [1:0]          fsm_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t state, state_next;

  // Handshakes: a cmd beat transfers on a cycle where cmd_valid & cmd_ready;
  // an IOb request completes on the cycle iob_valid & iob_ready (single-cycle
  // pulse); rsp_valid is a one-cycle pulse that the master cannot stall.
  logic              fifo_wr   [CMD_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [CMD_DEPTH];
  logic [DATA_W-1:0] fifo_data [CMD_DEPTH];
  logic [STRB_W-1:0] fifo_mask [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             push, pop, timeout_hit, in_req;
  logic              head_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [STRB_W-1:0] head_mask;

  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid & cmd_ready;
  assign in_req    = (state == REQ);
  assign pop       = in_req & (iob_ready | timeout_hit);
  assign busy      = (count != '0);
  assign fsm_state = state;

  assign head_wr   = fifo_wr[rd_ptr];
  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];
  assign head_mask = fifo_mask[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_ptr]   <= cmd_wr;
      fifo_addr[wr_ptr] <= cmd_address;
      fifo_data[wr_ptr] <= cmd_data;
      fifo_mask[wr_ptr] <= cmd_mask;
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
      logic [TO_W-1:0] to_cnt;

      always_ff @(posedge clk) begin
        if (rst || !in_req || pop) to_cnt <= '0;
        else if (!iob_ready)       to_cnt <= to_cnt + TO_W'(1);
      end

      assign timeout_hit = in_req & ~iob_ready & (to_cnt == TO_LAST);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // count_next is used so a push into an empty FIFO is issued the very next cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (count_next != '0) state_next = REQ;
      REQ: begin
        if (pop) begin
          if (timeout_hit)            state_next = ABORT;
          else if (count_next != '0)  state_next = REQ;
          else                        state_next = IDLE;
        end
      end
      ABORT: state_next = (count_next != '0) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    iob_valid   = in_req;
    iob_address = '0;
    iob_wdata   = '0;
    iob_wstrb   = '0;
    if (in_req) begin
      iob_address = head_addr;
      iob_wdata   = head_data;
      iob_wstrb   = head_wr ? head_mask : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      if (pop && (!head_wr || WRITE_RSP != 0)) begin
        rsp_valid <= 1'b1;
        rsp_error <= timeout_hit;
        rsp_data  <= (!head_wr && !timeout_hit) ? iob_rdata : '0;
      end
      if (timeout_hit) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iob_vexriscv_bus_bridge.sv
// Directed bench for iob_vexriscv_bus_bridge: a per-cycle vector table plus
// hand-written sequences for back-pressure, reset mid-flight and full-with-pop.
module tb_iob_vexriscv_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_wr, iob_ready;
  logic [31:0] cmd_address, cmd_data, iob_rdata;
  logic [3:0]  cmd_mask;

  logic        a_cmd_ready, a_rsp_valid, a_rsp_error, a_iob_valid, a_busy, a_err_sticky;
  logic [31:0] a_rsp_data, a_iob_address, a_iob_wdata;
  logic [3:0]  a_iob_wstrb;
  logic [1:0]  a_fsm_state;

  logic        b_cmd_ready, b_rsp_valid, b_rsp_error, b_iob_valid, b_busy, b_err_sticky;
  logic [31:0] b_rsp_data, b_iob_address, b_iob_wdata;
  logic [3:0]  b_iob_wstrb;
  logic [1:0]  b_fsm_state;

  iob_vexriscv_bus_bridge #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .WRITE_RSP(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_wr(cmd_wr),
    .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_error(a_rsp_error),
    .iob_valid(a_iob_valid), .iob_address(a_iob_address), .iob_wdata(a_iob_wdata),
    .iob_wstrb(a_iob_wstrb), .iob_ready(iob_ready), .iob_rdata(iob_rdata),
    .busy(a_busy), .err_sticky(a_err_sticky), .fsm_state(a_fsm_state)
  );

  iob_vexriscv_bus_bridge #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(2), .WRITE_RSP(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_wr(cmd_wr),
    .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_error(b_rsp_error),
    .iob_valid(b_iob_valid), .iob_address(b_iob_address), .iob_wdata(b_iob_wdata),
    .iob_wstrb(b_iob_wstrb), .iob_ready(iob_ready), .iob_rdata(iob_rdata),
    .busy(b_busy), .err_sticky(b_err_sticky), .fsm_state(b_fsm_state)
  );

  typedef struct {
    logic        cv, wr;
    logic [31:0] addr, data;
    logic [3:0]  mask;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_cr, e_iv;
    logic [31:0] e_ia, e_iw;
    logic [3:0]  e_ws;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_re, e_busy, e_err, chk_b, e_brv;
    logic [31:0] e_brd;
  } vec_t;

  localparam int NVEC = 21;
  vec_t        vecs [NVEC];
  logic [31:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;
  int          n_rsp = 0;

  function automatic vec_t mk(
    input logic cv, input logic wr, input logic [31:0] addr, input logic [31:0] data,
    input logic [3:0] mask, input logic rdy, input logic [31:0] rdata,
    input logic e_cr, input logic e_iv, input logic [31:0] e_ia, input logic [31:0] e_iw,
    input logic [3:0] e_ws, input logic e_rv, input logic [31:0] e_rd, input logic e_re,
    input logic e_busy, input logic e_err, input logic chk_b, input logic e_brv,
    input logic [31:0] e_brd);
    vec_t v;
    v.cv = cv; v.wr = wr; v.addr = addr; v.data = data; v.mask = mask;
    v.rdy = rdy; v.rdata = rdata; v.e_cr = e_cr; v.e_iv = e_iv; v.e_ia = e_ia;
    v.e_iw = e_iw; v.e_ws = e_ws; v.e_rv = e_rv; v.e_rd = e_rd; v.e_re = e_re;
    v.e_busy = e_busy; v.e_err = e_err; v.chk_b = chk_b; v.e_brv = e_brv; v.e_brd = e_brd;
    return v;
  endfunction

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_address = '0; cmd_data = '0; cmd_mask = '0;
    iob_ready = 1'b0; iob_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_rd(input logic [31:0] addr);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_address = addr; cmd_data = '0; cmd_mask = 4'hF;
  endtask

  // Scoreboard: every rsp beat of dut_a must match the head of exp_q.
  task automatic mon(input string tag);
    if (a_rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL %s unexpected rsp: got data %h want no beat", tag, a_rsp_data);
      end else begin
        chk({tag, " rsp_data"}, a_rsp_data, exp_q.pop_front());
        chk({tag, " rsp_error"}, {31'b0, a_rsp_error}, 32'd0);
      end
      n_rsp++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got no end want end");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_push, n_ready, w;
    bit started, gap, full_chk;

    rst = 1'b0;
    idle_in();

    // Rows: inputs of the cycle, then outputs expected in that same cycle.
    vecs[0]  = mk(1, 0, 'h100, 0, 'hF, 0, 0,                 1, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 'hDEADBEEF,              1, 1, 'h100, 0, 0,             0, 0, 0, 1, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0,                 1, 'hDEADBEEF, 0, 0, 0, 1, 1, 'hDEADBEEF);
    vecs[3]  = mk(1, 1, 'h200, 'h12345678, 'h3, 0, 0,        1, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0,                       1, 1, 'h200, 'h12345678, 'h3,  0, 0, 0, 1, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 'h11111111,              1, 1, 'h200, 'h12345678, 'h3,  0, 0, 0, 1, 0, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[8]  = mk(1, 0, 'h300, 0, 'hF, 0, 0,                 1, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 'h304, 0, 'hF, 0, 0,                 1, 1, 'h300, 0, 0,             0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 10; i <= 16; i++)
      vecs[i] = mk(0, 0, 0, 0, 0, 0, 0,                      1, 1, 'h300, 0, 0,             0, 0, 0, 1, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 'hBAD0BAD0,              1, 0, 0, 0, 0,                 1, 0, 1, 1, 1, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 1, 'hCAFEF00D,              1, 1, 'h304, 0, 0,             0, 0, 0, 1, 1, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0,                 1, 'hCAFEF00D, 0, 0, 1, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0,                 0, 0, 0, 0, 1, 0, 0, 0);

    do_reset();
    #1;
    chk("reset cmd_ready",   {31'b0, a_cmd_ready},  32'd1);
    chk("reset iob_valid",   {31'b0, a_iob_valid},  32'd0);
    chk("reset iob_address", a_iob_address,         32'd0);
    chk("reset iob_wdata",   a_iob_wdata,           32'd0);
    chk("reset iob_wstrb",   {28'b0, a_iob_wstrb},  32'd0);
    chk("reset rsp_valid",   {31'b0, a_rsp_valid},  32'd0);
    chk("reset rsp_data",    a_rsp_data,            32'd0);
    chk("reset rsp_error",   {31'b0, a_rsp_error},  32'd0);
    chk("reset busy",        {31'b0, a_busy},       32'd0);
    chk("reset err_sticky",  {31'b0, a_err_sticky}, 32'd0);
    chk("reset fsm_state",   {30'b0, a_fsm_state},  32'd0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      cmd_valid = vecs[i].cv; cmd_wr = vecs[i].wr; cmd_address = vecs[i].addr;
      cmd_data = vecs[i].data; cmd_mask = vecs[i].mask;
      iob_ready = vecs[i].rdy; iob_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d cmd_ready", i),   {31'b0, a_cmd_ready},  {31'b0, vecs[i].e_cr});
      chk($sformatf("v%0d iob_valid", i),   {31'b0, a_iob_valid},  {31'b0, vecs[i].e_iv});
      chk($sformatf("v%0d iob_address", i), a_iob_address,         vecs[i].e_ia);
      chk($sformatf("v%0d iob_wdata", i),   a_iob_wdata,           vecs[i].e_iw);
      chk($sformatf("v%0d iob_wstrb", i),   {28'b0, a_iob_wstrb},  {28'b0, vecs[i].e_ws});
      chk($sformatf("v%0d rsp_valid", i),   {31'b0, a_rsp_valid},  {31'b0, vecs[i].e_rv});
      chk($sformatf("v%0d rsp_data", i),    a_rsp_data,            vecs[i].e_rd);
      chk($sformatf("v%0d rsp_error", i),   {31'b0, a_rsp_error},  {31'b0, vecs[i].e_re});
      chk($sformatf("v%0d busy", i),        {31'b0, a_busy},       {31'b0, vecs[i].e_busy});
      chk($sformatf("v%0d err_sticky", i),  {31'b0, a_err_sticky}, {31'b0, vecs[i].e_err});
      if (vecs[i].chk_b) begin
        chk($sformatf("v%0d b rsp_valid", i), {31'b0, b_rsp_valid}, {31'b0, vecs[i].e_brv});
        chk($sformatf("v%0d b rsp_data", i),  b_rsp_data,           vecs[i].e_brd);
      end
    end

    // Reset while a request is outstanding: everything drops, late iob_ready is ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      push_rd(32'h700 + 32'(4 * k));
      iob_ready = 1'b0;
    end
    @(negedge clk);
    idle_in();
    #1;
    chk("mf iob_valid pre", {31'b0, a_iob_valid}, 32'd1);
    chk("mf busy pre",      {31'b0, a_busy},      32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk("mf iob_valid",  {31'b0, a_iob_valid},  32'd0);
    chk("mf busy",       {31'b0, a_busy},       32'd0);
    chk("mf cmd_ready",  {31'b0, a_cmd_ready},  32'd1);
    chk("mf err_sticky", {31'b0, a_err_sticky}, 32'd0);
    chk("mf rsp_valid",  {31'b0, a_rsp_valid},  32'd0);
    iob_ready = 1'b1;
    iob_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mf late rsp_valid %0d", k), {31'b0, a_rsp_valid}, 32'd0);
      chk($sformatf("mf late iob_valid %0d", k), {31'b0, a_iob_valid}, 32'd0);
    end
    idle_in();

    // Six reads against a slave with 3 wait states: FIFO fills, order kept, no gap.
    n_push = 0; n_ready = 0; n_rsp = 0; w = 0;
    started = 1'b0; gap = 1'b0; full_chk = 1'b0;
    for (int cyc = 0; cyc < 300 && n_rsp < 6; cyc++) begin
      @(negedge clk);
      #1;
      mon("bp");
      if (n_push == 4 && !full_chk) begin
        chk("bp cmd_ready full", {31'b0, a_cmd_ready}, 32'd0);
        full_chk = 1'b1;
      end
      iob_ready = 1'b0;
      iob_rdata = '0;
      if (a_iob_valid) begin
        started = 1'b1;
        w++;
        if (w == 4) begin
          iob_ready = 1'b1;
          iob_rdata = slave_data(a_iob_address);
          w = 0;
          n_ready++;
        end
      end else if (started && n_ready < 6) begin
        gap = 1'b1;
      end
      cmd_valid = (n_push < 6);
      cmd_wr = 1'b0; cmd_data = '0; cmd_mask = 4'hF;
      cmd_address = 32'h400 + 32'(4 * n_push);
      if (cmd_valid && a_cmd_ready) begin
        exp_q.push_back(slave_data(cmd_address));
        n_push++;
      end
    end
    idle_in();
    chk("bp rsp count",   n_rsp,                32'd6);
    chk("bp iob gap",     {31'b0, gap},         32'd0);
    chk("bp queue empty", exp_q.size(),         32'd0);
    chk("bp full seen",   {31'b0, full_chk},    32'd1);

    // Full FIFO with a pop in the same cycle as a new cmd: push waits one cycle.
    n_rsp = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("fp accept %0d", k), {31'b0, a_cmd_ready}, 32'd1);
      push_rd(32'h500 + 32'(4 * k));
      iob_ready = 1'b0;
      exp_q.push_back(slave_data(cmd_address));
    end
    @(negedge clk);
    #1;
    chk("fp full cmd_ready", {31'b0, a_cmd_ready}, 32'd0);
    chk("fp head address",   a_iob_address,        32'h500);
    push_rd(32'h600);
    iob_ready = 1'b1;
    iob_rdata = slave_data(a_iob_address);
    @(negedge clk);
    #1;
    mon("fp");
    chk("fp after pop cmd_ready", {31'b0, a_cmd_ready}, 32'd1);
    push_rd(32'h600);
    iob_ready = 1'b0;
    exp_q.push_back(slave_data(32'h600));
    @(negedge clk);
    #1;
    mon("fp");
    chk("fp refill cmd_ready", {31'b0, a_cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    iob_ready = a_iob_valid;
    iob_rdata = slave_data(a_iob_address);
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      #1;
      mon("fp");
      iob_ready = a_iob_valid;
      iob_rdata = slave_data(a_iob_address);
    end
    idle_in();
    @(negedge clk);
    #1;
    mon("fp");
    chk("fp rsp count",   n_rsp,                32'd5);
    chk("fp queue empty", exp_q.size(),         32'd0);
    chk("fp busy",        {31'b0, a_busy},      32'd0);
    chk("fp cmd_ready",   {31'b0, a_cmd_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
